mult_div_unit: RTL and testbench

Iterative 32-bit multiply/divide unit holding the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI, MTLO. Operands arrive from register-bank read ports (rs → Operand_A, rt → Operand_B). HI/LO feed the writeback mux for MFHI/MFLO. Multicycle: shift-add multiply and restoring division, one bit per cycle, with a Busy/Done handshake to the control unit.

---
 rtl/mult_div_unit_if.sv | 25 ++
 rtl/mult_div_unit.sv | 188 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Handshake and HI/LO bus between the control unit and the multiply/divide unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
   logic             Start;
   logic [1:0]       Op;
   logic [WIDTH-1:0] Operand_A;
   logic [WIDTH-1:0] Operand_B;
   logic             Write_HI;
   logic             Write_LO;
   logic [WIDTH-1:0] Write_Data;
   logic             Busy;
   logic             Done;
   logic             Div_By_Zero;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;

   modport master (
      output Start, Op, Operand_A, Operand_B, Write_HI, Write_LO, Write_Data,
      input  Busy, Done, Div_By_Zero, HI, LO
   );

   modport slave (
      input  Start, Op, Operand_A, Operand_B, Write_HI, Write_LO, Write_Data,
      output Busy, Done, Div_By_Zero, HI, LO
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO registers.
// One result bit per cycle; signed ops run on magnitudes with a final sign fix.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input logic             clk,
   input logic             reset_n,
   mult_div_unit_if.slave  bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      FINISH = 2'b10
   } state_t;

   state_t             state_r;
   logic [1:0]         op_r;
   logic [WIDTH-1:0]   mcand_r;
   logic [WIDTH-1:0]   mplier_r;
   logic [2*WIDTH-1:0] acc_r;
   logic [CW-1:0]      cnt_r;
   logic               neg_q_r;
   logic               neg_r_r;
   logic               dbz_r;
   logic               busy_r;
   logic               done_r;
   logic               dbz_pulse_r;
   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;

   logic               a_neg_s;
   logic               b_neg_s;
   logic [WIDTH-1:0]   a_mag_s;
   logic [WIDTH-1:0]   b_mag_s;
   logic [WIDTH:0]     mul_sum_s;
   logic [2*WIDTH-1:0] mul_next_s;
   logic [WIDTH+1:0]   div_trial_s;
   logic [2*WIDTH-1:0] div_next_s;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   quot_s;
   logic [WIDTH-1:0]   rem_s;
   logic [WIDTH-1:0]   res_hi_s;
   logic [WIDTH-1:0]   res_lo_s;

   // Operand magnitudes and sign flags captured at Start (Op[0]=0 means signed).
   always_comb begin
      a_neg_s = ~bus.Op[0] & bus.Operand_A[WIDTH-1];
      b_neg_s = ~bus.Op[0] & bus.Operand_B[WIDTH-1];
      if (a_neg_s) begin
         a_mag_s = {WIDTH{1'b0}} - bus.Operand_A;
      end else begin
         a_mag_s = bus.Operand_A;
      end
      if (b_neg_s) begin
         b_mag_s = {WIDTH{1'b0}} - bus.Operand_B;
      end else begin
         b_mag_s = bus.Operand_B;
      end
   end

   // One iteration step of each algorithm plus the sign-corrected final result.
   always_comb begin
      if (mplier_r[0]) begin
         mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
      end else begin
         mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
      end
      mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};

      // Shifted remainder can reach WIDTH+1 bits, so the trial keeps a borrow bit above that.
      div_trial_s = {1'b0, acc_r[2*WIDTH-1:WIDTH-1]} - {2'b00, mplier_r};
      if (div_trial_s[WIDTH+1]) begin
         div_next_s = {acc_r[2*WIDTH-2:0], 1'b0};
      end else begin
         div_next_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end

      if (neg_q_r) begin
         prod_s = {(2*WIDTH){1'b0}} - acc_r;
         quot_s = {WIDTH{1'b0}} - acc_r[WIDTH-1:0];
      end else begin
         prod_s = acc_r;
         quot_s = acc_r[WIDTH-1:0];
      end
      if (neg_r_r) begin
         rem_s = {WIDTH{1'b0}} - acc_r[2*WIDTH-1:WIDTH];
      end else begin
         rem_s = acc_r[2*WIDTH-1:WIDTH];
      end
      if (op_r[1]) begin
         res_hi_s = rem_s;
         res_lo_s = quot_s;
      end else begin
         res_hi_s = prod_s[2*WIDTH-1:WIDTH];
         res_lo_s = prod_s[WIDTH-1:0];
      end
   end

   // Control FSM, iteration datapath and architectural HI/LO registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         op_r        <= 2'b00;
         mcand_r     <= {WIDTH{1'b0}};
         mplier_r    <= {WIDTH{1'b0}};
         acc_r       <= {(2*WIDTH){1'b0}};
         cnt_r       <= {CW{1'b0}};
         neg_q_r     <= 1'b0;
         neg_r_r     <= 1'b0;
         dbz_r       <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         dbz_pulse_r <= 1'b0;
         hi_r        <= {WIDTH{1'b0}};
         lo_r        <= {WIDTH{1'b0}};
      end else begin
         done_r      <= 1'b0;
         dbz_pulse_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.Start) begin
                  op_r     <= bus.Op;
                  mcand_r  <= a_mag_s;
                  mplier_r <= b_mag_s;
                  // Divides start with the dividend in the quotient half.
                  if (bus.Op[1]) begin
                     acc_r <= {{WIDTH{1'b0}}, a_mag_s};
                  end else begin
                     acc_r <= {(2*WIDTH){1'b0}};
                  end
                  cnt_r   <= {CW{1'b0}};
                  neg_q_r <= a_neg_s ^ b_neg_s;
                  neg_r_r <= a_neg_s;
                  dbz_r   <= bus.Op[1] & (bus.Operand_B == {WIDTH{1'b0}});
                  busy_r  <= 1'b1;
                  if (bus.Op[1] && (bus.Operand_B == {WIDTH{1'b0}})) begin
                     state_r <= FINISH;
                  end else begin
                     state_r <= RUN;
                  end
               end else begin
                  if (bus.Write_HI) begin
                     hi_r <= bus.Write_Data;
                  end
                  if (bus.Write_LO) begin
                     lo_r <= bus.Write_Data;
                  end
               end
            end
            RUN: begin
               if (op_r[1]) begin
                  acc_r <= div_next_s;
               end else begin
                  acc_r    <= mul_next_s;
                  mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
               end
               cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
               if (cnt_r == LAST_CNT) begin
                  state_r <= FINISH;
               end
            end
            FINISH: begin
               if (!dbz_r) begin
                  hi_r <= res_hi_s;
                  lo_r <= res_lo_s;
               end
               done_r      <= 1'b1;
               dbz_pulse_r <= dbz_r;
               busy_r      <= 1'b0;
               state_r     <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.Busy        = busy_r;
   assign bus.Done        = done_r;
   assign bus.Div_By_Zero = dbz_pulse_r;
   assign bus.HI          = hi_r;
   assign bus.LO          = lo_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus randomized ops
// compared against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;
   localparam int W = 32;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   int          n_cmp = 0;
   int          n_mis = 0;
   logic [31:0] hi_m = 32'h0;
   logic [31:0] lo_m = 32'h0;

   mult_div_unit_if #(.WIDTH(W)) bus ();

   mult_div_unit #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Returns {HI, LO} from plain signed/unsigned 64-bit arithmetic.
   function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: begin p = 64'(sa * sb); return p; end
         2'b01: begin p = {32'h0, a} * {32'h0, b}; return p; end
         2'b10: begin q = sa / sb; r = sa % sb; return {r[31:0], q[31:0]}; end
         default: return {a % b, a / b};
      endcase
   endfunction

   // Called at a negedge; issues Start there and returns at the negedge of the Done cycle.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit wlo, input string tag);
      logic [63:0] r;
      bit          dz;
      bit          busy_ok;
      int          lat;
      int          cyc;
      dz  = op[1] && (b == 32'h0);
      lat = dz ? 2 : 34;
      r   = dz ? {hi_m, lo_m} : ref_model(op, a, b);
      bus.Start = 1'b1; bus.Op = op; bus.Operand_A = a; bus.Operand_B = b;
      bus.Write_LO = wlo; bus.Write_Data = $urandom;
      @(negedge clk);
      bus.Start = 1'b0; bus.Write_LO = 1'b0;
      bus.Operand_A = $urandom; bus.Operand_B = $urandom; bus.Op = 2'($urandom_range(0, 3));
      cyc = 1;
      busy_ok = 1'b1;
      while (!bus.Done && cyc < 100) begin
         if (!bus.Busy) busy_ok = 1'b0;
         @(negedge clk);
         cyc++;
      end
      hi_m = r[63:32];
      lo_m = r[31:0];
      check_eq({tag, "_latency"}, 64'(cyc), 64'(lat));
      check_eq({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
      check_eq({tag, "_busy_at_done"}, 64'(bus.Busy), 64'd0);
      check_eq({tag, "_dbz"}, 64'(bus.Div_By_Zero), 64'(dz));
      check_eq({tag, "_hi"}, 64'(bus.HI), 64'(hi_m));
      check_eq({tag, "_lo"}, 64'(bus.LO), 64'(lo_m));
   endtask

   task automatic mt_write(input bit to_hi, input logic [31:0] d);
      bus.Write_HI = to_hi; bus.Write_LO = !to_hi; bus.Write_Data = d;
      @(negedge clk);
      bus.Write_HI = 1'b0; bus.Write_LO = 1'b0;
      if (to_hi) hi_m = d; else lo_m = d;
      check_eq("mt_hi", 64'(bus.HI), 64'(hi_m));
      check_eq("mt_lo", 64'(bus.LO), 64'(lo_m));
   endtask

   initial begin
      logic [1:0]  op;
      logic [31:0] a, b;
      bit          done_seen;

      bus.Start = 1'b0; bus.Op = 2'b00; bus.Operand_A = 32'h0; bus.Operand_B = 32'h0;
      bus.Write_HI = 1'b0; bus.Write_LO = 1'b0; bus.Write_Data = 32'h0;
      repeat (3) @(negedge clk);
      check_eq("rst_busy", 64'(bus.Busy), 64'd0);
      check_eq("rst_done", 64'(bus.Done), 64'd0);
      check_eq("rst_dbz", 64'(bus.Div_By_Zero), 64'd0);
      check_eq("rst_hi", 64'(bus.HI), 64'd0);
      check_eq("rst_lo", 64'(bus.LO), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);

      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "multu_max");
      check_eq("multu_max_hi_const", 64'(bus.HI), 64'hFFFFFFFE);
      check_eq("multu_max_lo_const", 64'(bus.LO), 64'h00000001);

      run_op(2'b00, 32'hFFFFFFFD, 32'd7, 1'b0, "mult_neg");
      check_eq("mult_neg_lo_const", 64'(bus.LO), 64'hFFFFFFEB);
      run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, "div_b2b");
      check_eq("div_b2b_lo_const", 64'(bus.LO), 64'hFFFFFFFD);
      check_eq("div_b2b_hi_const", 64'(bus.HI), 64'hFFFFFFFF);

      mt_write(1'b1, 32'h1234);
      mt_write(1'b0, 32'h5678);
      run_op(2'b11, 32'd100, 32'd0, 1'b0, "divu_zero");
      check_eq("divu_zero_hi_const", 64'(bus.HI), 64'h1234);
      check_eq("divu_zero_lo_const", 64'(bus.LO), 64'h5678);

      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");
      check_eq("div_ovf_lo_const", 64'(bus.LO), 64'h80000000);
      check_eq("div_ovf_hi_const", 64'(bus.HI), 64'h0);

      @(negedge clk);
      run_op(2'b01, 32'd2, 32'd3, 1'b1, "start_wins");
      check_eq("start_wins_lo_const", 64'(bus.LO), 64'd6);
      run_op(2'b11, 32'd5, 32'd0, 1'b1, "dbz_drop_mtlo");

      // Abort: MULTU started in cycle 0, ignored Start/MTHI in cycle 5, reset in cycle 10.
      done_seen = 1'b0;
      bus.Start = 1'b1; bus.Op = 2'b01; bus.Operand_A = 32'd5; bus.Operand_B = 32'd6;
      @(negedge clk);
      bus.Start = 1'b0;
      repeat (4) begin
         done_seen |= bus.Done;
         @(negedge clk);
      end
      bus.Start = 1'b1; bus.Op = 2'b11; bus.Operand_A = 32'd9; bus.Operand_B = 32'd3;
      bus.Write_HI = 1'b1; bus.Write_Data = 32'hDEADBEEF;
      @(negedge clk);
      bus.Start = 1'b0; bus.Write_HI = 1'b0;
      check_eq("abort_busy_c6", 64'(bus.Busy), 64'd1);
      check_eq("abort_mthi_ignored", 64'(bus.HI), 64'(hi_m));
      repeat (4) begin
         done_seen |= bus.Done;
         @(negedge clk);
      end
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      hi_m = 32'h0;
      lo_m = 32'h0;
      check_eq("abort_busy_c11", 64'(bus.Busy), 64'd0);
      check_eq("abort_hi", 64'(bus.HI), 64'(hi_m));
      check_eq("abort_lo", 64'(bus.LO), 64'(lo_m));
      repeat (40) begin
         done_seen |= bus.Done;
         @(negedge clk);
      end
      check_eq("abort_no_done", 64'(done_seen), 64'd0);
      check_eq("abort_hi_after", 64'(bus.HI), 64'(hi_m));

      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0: begin a = $urandom; b = $urandom; end
            1: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(0, 9)); end
            2: begin a = $urandom | 32'h80000000; b = $urandom_range(0, 1) ? 32'hFFFFFFFF : $urandom; end
            default: begin a = $urandom; b = 32'($urandom_range(0, 255)); end
         endcase
         if ($urandom_range(0, 7) == 0) b = 32'h0;
         if ($urandom_range(0, 3) == 0) mt_write(1'($urandom_range(0, 1)), $urandom);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
         run_op(op, a, b, 1'($urandom_range(0, 1)), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
